axis_neuron_mac: RTL and testbench
==================================

// Module: axis_neuron_mac
// PURPOSE
//  AXI-Stream neuron stage placed directly downstream of axis_fifo_v1_0 master port.
//  Consumes one packet (tlast-delimited) of signed Q(32-FRAC_BITS).FRAC_BITS activations, multiplies
//  beat i by weight[i], accumulates, adds bias, applies ReLU, emits one single-beat result packet.
//  Weights/bias are loaded through a simple register-write port by the control logic.
// PARAMETERS
//  DATA_WIDTH  32  stream and weight width (signed two's complement)
//  FRAC_BITS   16  fractional bits of activations, weights, bias, result
//  ADDR_WIDTH  4   weight index width; MAX_LEN = 2**ADDR_WIDTH beats per packet
//  ACC_WIDTH   48  signed accumulator width
// PORTS
//  aclk           in   1             single clock, rising edge
//  areset         in   1             synchronous, active-high reset
//  s_axis_tdata   in   DATA_WIDTH    input activation
//  s_axis_tstrb   in   DATA_WIDTH/8  ignored
//  s_axis_tvalid  in   1             input beat valid
//  s_axis_tready  out  1             input beat accepted when tvalid&tready
//  s_axis_tlast   in   1             last beat of packet
//  m_axis_tdata   out  DATA_WIDTH    neuron result
//  m_axis_tstrb   out  DATA_WIDTH/8  constant all-ones
//  m_axis_tvalid  out  1             result valid
//  m_axis_tready  in   1             downstream ready
//  m_axis_tlast   out  1             1 whenever m_axis_tvalid
//  w_we           in   1             weight/bias write strobe
//  w_addr         in   ADDR_WIDTH+1  MSB=1 selects bias, else weight[w_addr[ADDR_WIDTH-1:0]]
//  w_data         in   DATA_WIDTH    write data
//  len_err        out  1             sticky: packet exceeded MAX_LEN beats; cleared by reset only
// BEHAVIOUR
//  Reset: state=ACCUM, acc=0, idx=0, s_axis_tready=0 during reset cycle then 1, m_axis_tvalid=0,
//   m_axis_tdata=0, len_err=0. Weight/bias storage NOT reset (contents retained).
//  FSM ACCUM: s_axis_tready=1; per accepted beat: prod = (tdata*weight[idx]) >>> FRAC_BITS
//   (full 2*DATA_WIDTH signed product, arithmetic shift, truncate toward -inf), acc += sign-extended prod
//   (wraps modulo ACC_WIDTH), idx++. Beats with idx >= MAX_LEN contribute 0 and set len_err.
//   Accepted beat with tlast -> OUTPUT; result registered: m_axis_tvalid=1 the cycle after the tlast beat.
//  Result = ReLU(sat_DATA_WIDTH(acc_final + sign-extended bias)); negative -> 0, > max -> 2^(DATA_WIDTH-1)-1.
//  FSM OUTPUT: s_axis_tready=0; tdata/tlast held stable until m_axis_tvalid&m_axis_tready;
//   on handshake: m_axis_tvalid=0, acc=0, idx=0, -> ACCUM (s_axis_tready=1 next cycle).
//  Latency tlast-accept -> m_axis_tvalid: 1 cycle. Throughput: 1 beat/cycle in ACCUM; 1 bubble per packet min.
//  Single-beat packet (tvalid&tlast first beat) valid: result = ReLU(x*w[0]+bias).
//  s_axis_tvalid low mid-packet: acc/idx hold. tvalid with tready=0 in OUTPUT: beat not consumed.
//  Weight write: takes effect at clock edge; a beat read in the same cycle uses the old value.
//   Writes during ACCUM are legal but affect remaining beats; control must write only between packets.
//  areset asserted mid-packet or mid-OUTPUT: partial packet/result discarded, reset values next cycle.
// STRUCTURE
//  Shared package axis_nn_pkg: DATA_WIDTH, FRAC_BITS, ACC_WIDTH defaults; state enum {ACCUM, OUTPUT};
//   saturate/ReLU constants (DATA_MAX, DATA_MIN).
//  One sub-module: nn_weight_regfile (2**ADDR_WIDTH+1 registers, 1 write port, 2 async read: weight[idx], bias).
//  Top holds FSM, idx counter, multiplier, accumulator, saturate/ReLU, output register.
// TESTING (FRAC_BITS=16; 1.0 = 0x00010000)
//  1 weights all 1.0, bias 0; packet 1.0,2.0,3.0,4.0,5.0 (tlast on 5.0), m_tready=1 -> one beat 0x000F0000,
//    tlast=1, tvalid exactly 1 cycle after tlast beat, s_tready low that cycle.
//  2 weights 0.5 (0x8000), bias -1.0; packet 100,200,300,400,500 (raw ints) -> acc 750, result 0 (ReLU);
//    bias +1.0 -> 0x000102EE.
//  3 weight[0]=2.0, packet 0x7FFF0000 single beat -> 0x7FFFFFFF (saturation); x=-1.0 -> 0x00000000.
//  4 m_tready low 5 cycles after result -> tdata/tvalid stable, s_tready=0, input beat offered not consumed;
//    m_tready high -> handshake, next packet accepted and computed correctly.
//  5 packet of 18 beats of 1.0, weights 1.0 -> result 0x00100000 (16 counted), len_err=1 and stays 1.
//  6 areset for 1 cycle after 3 beats, then full packet 1.0,2.0 -> result 0x00030000 (no carry-over).

Source files
------------

// File: rtl/axis_nn_pkg.sv
// Shared definitions for the AXI-Stream neuron stage: default widths, FSM states
// and the signed result bounds at the default data width.
package axis_nn_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefFracBits  = 16;
  localparam int unsigned DefAddrWidth = 4;
  localparam int unsigned DefAccWidth  = 48;

  typedef enum logic [0:0] {
    StAccum,
    StOutput
  } state_e;

  localparam logic signed [DefDataWidth-1:0] DataMax = {1'b0, {(DefDataWidth-1){1'b1}}};
  localparam logic signed [DefDataWidth-1:0] DataMin = {1'b1, {(DefDataWidth-1){1'b0}}};

endpackage

// File: rtl/nn_weight_regfile.sv
// Weight and bias storage: one write port, asynchronous reads of the current
// weight and the bias. Contents are deliberately not reset.
module nn_weight_regfile
  import axis_nn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_weight,
  output logic [DATA_WIDTH-1:0] o_bias
);

  localparam int unsigned MaxLen = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_weight [MaxLen];
  logic [DATA_WIDTH-1:0] r_bias;

  // Address MSB selects the bias register.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      if (i_waddr[ADDR_WIDTH]) begin
        r_bias <= i_wdata;
      end else begin
        r_weight[i_waddr[ADDR_WIDTH-1:0]] <= i_wdata;
      end
    end
  end

  assign o_weight = r_weight[i_raddr];
  assign o_bias   = r_bias;

endmodule

// File: rtl/axis_neuron_mac.sv
// AXI-Stream neuron: weighted sum of one tlast-delimited packet plus bias,
// saturated and rectified, emitted as a single-beat result packet.
module axis_neuron_mac
  import axis_nn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned FRAC_BITS  = DefFracBits,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned ACC_WIDTH  = DefAccWidth
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  input  logic                    w_we,
  input  logic [ADDR_WIDTH:0]     w_addr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  output logic                    len_err
);

  localparam logic signed [DATA_WIDTH-1:0] SatMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  state_e                        r_state;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic        [ADDR_WIDTH:0]    r_idx;
  logic                          r_valid;
  logic        [DATA_WIDTH-1:0]  r_tdata;
  logic                          r_len_err;

  logic signed [DATA_WIDTH-1:0]   w_weight;
  logic signed [DATA_WIDTH-1:0]   w_bias;
  logic                           w_beat;
  logic                           w_ovf;
  logic signed [2*DATA_WIDTH-1:0] w_prod_full;
  logic signed [2*DATA_WIDTH-1:0] w_prod_sh;
  logic signed [ACC_WIDTH-1:0]    w_prod;
  logic signed [ACC_WIDTH-1:0]    w_acc_next;
  logic signed [ACC_WIDTH:0]      w_sum;
  logic        [DATA_WIDTH-1:0]   w_result;
  logic                           w_unused_tstrb;

  nn_weight_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_regfile (
    .i_clk   (aclk),
    .i_we    (w_we),
    .i_waddr (w_addr),
    .i_wdata (w_data),
    .i_raddr (r_idx[ADDR_WIDTH-1:0]),
    .o_weight(w_weight),
    .o_bias  (w_bias)
  );

  assign w_unused_tstrb = ^s_axis_tstrb;
  assign s_axis_tready  = (r_state == StAccum) & ~areset;
  assign w_beat         = s_axis_tvalid & s_axis_tready;
  // r_idx saturates at MAX_LEN; its MSB marks beats beyond the weight table.
  assign w_ovf          = r_idx[ADDR_WIDTH];

  always_comb begin
    w_prod_full = $signed(s_axis_tdata) * w_weight;
    w_prod_sh   = w_prod_full >>> FRAC_BITS;
    w_prod      = w_ovf ? '0 : ACC_WIDTH'(w_prod_sh);
    w_acc_next  = r_acc + w_prod;
    w_sum       = (ACC_WIDTH+1)'(w_acc_next) + (ACC_WIDTH+1)'(w_bias);
    if (w_sum[ACC_WIDTH]) begin
      w_result = '0;
    end else if (w_sum > (ACC_WIDTH+1)'(SatMax)) begin
      w_result = SatMax;
    end else begin
      w_result = w_sum[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= StAccum;
      r_acc     <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_tdata   <= '0;
      r_len_err <= 1'b0;
    end else begin
      unique case (r_state)
        StAccum: begin
          if (w_beat) begin
            if (w_ovf) begin
              r_len_err <= 1'b1;
            end
            if (s_axis_tlast) begin
              r_tdata <= w_result;
              r_valid <= 1'b1;
              r_state <= StOutput;
            end else begin
              r_acc <= w_acc_next;
              if (!w_ovf) begin
                r_idx <= r_idx + (ADDR_WIDTH+1)'(1);
              end
            end
          end
        end
        StOutput: begin
          if (m_axis_tready) begin
            r_valid <= 1'b0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= StAccum;
          end
        end
        default: r_state <= StAccum;
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_valid;
  assign m_axis_tlast  = r_valid;
  assign m_axis_tstrb  = '1;
  assign len_err       = r_len_err;

endmodule

// File: tb/tb_axis_neuron_mac.sv
// Bench for axis_neuron_mac: directed fixed-point cases plus randomized packets
// checked against an arithmetic model of the neuron.
module tb_axis_neuron_mac;
  import axis_nn_pkg::*;

  logic        aclk;
  logic        areset;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        len_err;

  int   n_cmp;
  int   n_bad;
  int   m_w [16];
  int   m_bias;
  logic m_len_err;

  axis_neuron_mac dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis_tdata (s_tdata),
    .s_axis_tstrb (s_tstrb),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tstrb (m_tstrb),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .w_we         (w_we),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .len_err      (len_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Fixed-point neuron: sum of (x*w)>>>16 over the first 16 beats, 48-bit wrap,
  // plus bias, then clamp to [0, DataMax].
  function automatic logic [31:0] model(input logic [31:0] pkt[$]);
    logic signed [47:0] acc;
    longint             p;
    longint             sum;
    acc = '0;
    foreach (pkt[i]) begin
      if (i < 16) begin
        p   = (longint'($signed(pkt[i])) * longint'(m_w[i])) >>> 16;
        acc = acc + 48'(p);
      end
    end
    sum = longint'(acc) + longint'(m_bias);
    if (sum < 0) return 32'h0;
    if (sum > longint'(DataMax)) return DataMax;
    return 32'(sum);
  endfunction

  task automatic write_w(input int addr, input logic [31:0] d);
    w_we   = 1'b1;
    w_addr = addr[4:0];
    w_data = d;
    @(posedge aclk);
    #1;
    w_we = 1'b0;
    if (addr >= 16) m_bias = int'(d);
    else m_w[addr] = int'(d);
  endtask

  task automatic set_all(input logic [31:0] w, input logic [31:0] b);
    for (int i = 0; i < 16; i++) write_w(i, w);
    write_w(16, b);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    n        = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    while (!s_tready && n < 50) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check_eq("s_tready_wait", s_tready, 1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic run_packet(input logic [31:0] pkt[$], input int stall, input bit gaps,
                            input string tag, output logic [31:0] got);
    logic [31:0] exp;
    exp      = model(pkt);
    m_tready = (stall == 0);
    foreach (pkt[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge aclk);
          #1;
        end
      end
      send_beat(pkt[i], i == pkt.size() - 1);
    end
    if (pkt.size() > 16) m_len_err = 1'b1;
    got = m_tdata;
    check_eq({tag, "_valid"}, m_tvalid, 1);
    check_eq({tag, "_tlast"}, m_tlast, 1);
    check_eq({tag, "_sready"}, s_tready, 0);
    check_eq({tag, "_data"}, m_tdata, exp);
    for (int c = 0; c < stall; c++) begin
      @(posedge aclk);
      #1;
      check_eq({tag, "_hold_v"}, m_tvalid, 1);
      check_eq({tag, "_hold_d"}, m_tdata, exp);
    end
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    check_eq({tag, "_done"}, m_tvalid, 0);
    check_eq({tag, "_lenerr"}, len_err, m_len_err);
  endtask

  initial begin
    logic [31:0] pkt[$];
    logic [31:0] got;
    logic [31:0] exp;
    n_cmp     = 0;
    n_bad     = 0;
    m_len_err = 1'b0;
    areset    = 1'b1;
    s_tdata   = '0;
    s_tstrb   = 4'hF;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    m_tready  = 1'b1;
    w_we      = 1'b0;
    w_addr    = '0;
    w_data    = '0;

    repeat (2) @(posedge aclk);
    #1;
    check_eq("rst_sready", s_tready, 0);
    check_eq("rst_mvalid", m_tvalid, 0);
    check_eq("rst_mdata", m_tdata, 0);
    check_eq("rst_lenerr", len_err, 0);
    areset = 1'b0;
    #1;
    check_eq("rst_sready_after", s_tready, 1);
    check_eq("tstrb_ones", m_tstrb, 4'hF);

    // 1: unit weights, sum of 1..5
    set_all(32'h0001_0000, 32'h0);
    pkt = {};
    for (int i = 1; i <= 5; i++) pkt.push_back(32'(i) << 16);
    run_packet(pkt, 0, 1'b0, "t1", got);
    check_eq("t1_const", got, 32'h000F_0000);

    // 2: half weights on raw integers, bias -1.0 then +1.0
    set_all(32'h0000_8000, 32'hFFFF_0000);
    pkt = {32'd100, 32'd200, 32'd300, 32'd400, 32'd500};
    run_packet(pkt, 0, 1'b0, "t2n", got);
    check_eq("t2n_const", got, 32'h0);
    write_w(16, 32'h0001_0000);
    run_packet(pkt, 0, 1'b0, "t2p", got);
    check_eq("t2p_const", got, 32'h0001_02EE);

    // 3: saturation and negative clamp
    write_w(0, 32'h0002_0000);
    write_w(16, 32'h0);
    pkt = {32'h7FFF_0000};
    run_packet(pkt, 0, 1'b0, "t3s", got);
    check_eq("t3s_const", got, 32'h7FFF_FFFF);
    pkt = {32'hFFFF_0000};
    run_packet(pkt, 0, 1'b0, "t3n", got);
    check_eq("t3n_const", got, 32'h0);

    // 4: backpressure with a beat offered while the result is held
    set_all(32'h0001_0000, 32'h0);
    pkt      = {32'h0001_0000, 32'h0002_0000};
    exp      = model(pkt);
    m_tready = 1'b0;
    send_beat(pkt[0], 1'b0);
    send_beat(pkt[1], 1'b1);
    check_eq("t4_valid", m_tvalid, 1);
    s_tdata  = 32'h0003_0000;
    s_tvalid = 1'b1;
    s_tlast  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge aclk);
      #1;
      check_eq("t4_hold_v", m_tvalid, 1);
      check_eq("t4_hold_d", m_tdata, exp);
      check_eq("t4_hold_sready", s_tready, 0);
    end
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    check_eq("t4_hs_v", m_tvalid, 0);
    check_eq("t4_hs_sready", s_tready, 1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check_eq("t4_next_v", m_tvalid, 1);
    check_eq("t4_next_d", m_tdata, 32'h0003_0000);
    @(posedge aclk);
    #1;
    check_eq("t4_next_done", m_tvalid, 0);

    // 5: over-length packet
    pkt = {};
    for (int i = 0; i < 18; i++) pkt.push_back(32'h0001_0000);
    run_packet(pkt, 0, 1'b0, "t5", got);
    check_eq("t5_const", got, 32'h0010_0000);
    check_eq("t5_lenerr", len_err, 1);
    pkt = {32'h0001_0000};
    run_packet(pkt, 0, 1'b0, "t5b", got);
    check_eq("t5b_lenerr_sticky", len_err, 1);

    // 6: reset mid-packet discards partial sum
    for (int i = 0; i < 3; i++) send_beat(32'h0001_0000, 1'b0);
    areset = 1'b1;
    #1;
    check_eq("t6_rst_sready", s_tready, 0);
    @(posedge aclk);
    #1;
    areset    = 1'b0;
    m_len_err = 1'b0;
    #1;
    check_eq("t6_mvalid", m_tvalid, 0);
    check_eq("t6_lenerr", len_err, 0);
    pkt = {32'h0001_0000, 32'h0002_0000};
    run_packet(pkt, 0, 1'b0, "t6", got);
    check_eq("t6_const", got, 32'h0003_0000);

    // Randomized packets, weights, bias, gaps and stalls
    for (int r = 0; r < 40; r++) begin
      int len;
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) write_w(i, 32'(int'($urandom) >>> $urandom_range(8, 14)));
      end
      if ($urandom_range(0, 1) == 0) write_w(16, 32'(int'($urandom) >>> $urandom_range(4, 12)));
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 18)) : int'($urandom_range(1, 16));
      pkt = {};
      for (int i = 0; i < len; i++) pkt.push_back(32'(int'($urandom) >>> $urandom_range(0, 12)));
      run_packet(pkt, int'($urandom_range(0, 3)), 1'b1, "rnd", got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
